// File: rtl/uart_tx_feeder.sv
// Byte FIFO and launch sequencer feeding a slow UART transmitter.
// Bytes are queued at any rate. Each byte is popped only when the transmitter is idle. It is then
// launched with a one-cycle start pulse. If the transmitter never acknowledges with busy, the
// start pulse is repeated after a timeout.
module uart_tx_feeder #(
  parameter int unsigned DEPTH   = 16,
  parameter int unsigned AW      = 4,
  parameter int unsigned TIMEOUT = 4
) (
  input  logic          clk_i,
  input  logic          rst_i,
  input  logic          wr_en_i,
  input  logic [7:0]    wr_data_i,
  output logic          full_o,
  output logic          empty_o,
  output logic [AW:0]   count_o,
  output logic          overflow_o,
  input  logic          clr_ovf_i,
  output logic          tx_start_o,
  output logic [7:0]    tx_data_o,
  input  logic          tx_busy_i
);

  localparam logic [AW:0] FullCnt = (AW + 1)'(DEPTH);
  localparam logic [3:0]  TmoLast = 4'(TIMEOUT - 1);

  typedef enum logic [1:0] {StIdle, StLaunch, StWaitHi, StWaitLo} state_e;

  state_e          state_q, state_d;
  logic [7:0]      mem_q [DEPTH];
  logic [AW-1:0]   wr_ptr_q, wr_ptr_d;
  logic [AW-1:0]   rd_ptr_q, rd_ptr_d;
  logic [AW:0]     count_q, count_d;
  logic            ovf_q, ovf_d;
  logic [7:0]      tx_data_q, tx_data_d;
  logic [3:0]      tmo_q, tmo_d;

  logic            full, empty, do_write, do_pop;

  // Status flags decoded from registered count only.
  always_comb begin
    full     = (count_q == FullCnt);
    empty    = (count_q == '0);
    do_write = wr_en_i && !full;
    do_pop   = (state_q == StIdle) && !empty && !tx_busy_i;
  end

  // Launch sequencer next-state logic.
  always_comb begin
    state_d = state_q;
    tmo_d   = tmo_q;
    unique case (state_q)
      StIdle: begin
        if (do_pop) state_d = StLaunch;
      end
      StLaunch: begin
        state_d = StWaitHi;
        tmo_d   = '0;
      end
      StWaitHi: begin
        if (tx_busy_i) begin
          state_d = StWaitLo;
        end else if (tmo_q == TmoLast) begin
          // Transmitter missed the pulse: re-launch the same byte.
          state_d = StLaunch;
        end else begin
          tmo_d = tmo_q + 4'd1;
        end
      end
      StWaitLo: begin
        if (!tx_busy_i) state_d = StIdle;
      end
      default: state_d = StIdle;
    endcase
  end

  // FIFO pointer, occupancy, overflow and launch-data next-state logic.
  always_comb begin
    wr_ptr_d  = do_write ? wr_ptr_q + AW'(1) : wr_ptr_q;
    rd_ptr_d  = do_pop ? rd_ptr_q + AW'(1) : rd_ptr_q;
    count_d   = count_q;
    if (do_write && !do_pop) begin
      count_d = count_q + (AW + 1)'(1);
    end else if (!do_write && do_pop) begin
      count_d = count_q - (AW + 1)'(1);
    end
    tx_data_d = do_pop ? mem_q[rd_ptr_q] : tx_data_q;
    // A dropped write takes priority over a simultaneous clear.
    if (wr_en_i && full) begin
      ovf_d = 1'b1;
    end else if (clr_ovf_i) begin
      ovf_d = 1'b0;
    end else begin
      ovf_d = ovf_q;
    end
  end

  // Control and datapath registers with synchronous reset.
  always_ff @(posedge clk_i) begin
    if (rst_i) begin
      state_q   <= StIdle;
      wr_ptr_q  <= '0;
      rd_ptr_q  <= '0;
      count_q   <= '0;
      ovf_q     <= 1'b0;
      tx_data_q <= 8'h00;
      tmo_q     <= '0;
    end else begin
      state_q   <= state_d;
      wr_ptr_q  <= wr_ptr_d;
      rd_ptr_q  <= rd_ptr_d;
      count_q   <= count_d;
      ovf_q     <= ovf_d;
      tx_data_q <= tx_data_d;
      tmo_q     <= tmo_d;
    end
  end

  // Byte storage; contents are don't-care after reset since the pointers are cleared.
  always_ff @(posedge clk_i) begin
    if (!rst_i && do_write) begin
      mem_q[wr_ptr_q] <= wr_data_i;
    end
  end

  assign full_o     = full;
  assign empty_o    = empty;
  assign count_o    = count_q;
  assign overflow_o = ovf_q;
  assign tx_start_o = (state_q == StLaunch);
  assign tx_data_o  = tx_data_q;

endmodule

// File: tb/tb_uart_tx_feeder.sv
// Testbench for uart_tx_feeder: a DEPTH=16 instance drives a serial transmitter model,
// a DEPTH=4 instance has its busy input driven directly for the wrap/simultaneous sequence.
module tb_uart_tx_feeder;

  localparam int BitCyc = 4;
  localparam logic [9:0] ExpFrame = {1'b1, 8'hA5, 1'b0};

  logic       clk = 1'b0;
  logic       rst = 1'b1;
  logic       wr_en = 1'b0;
  logic       clr_ovf = 1'b0;
  logic [7:0] wr_data = 8'h00;

  logic       full, empty, ovf, tx_start, tx_busy;
  logic [4:0] count;
  logic [7:0] tx_data;

  logic       full4, empty4, ovf4, tx_start4;
  logic       busy4 = 1'b1;
  logic [2:0] count4;
  logic [7:0] tx_data4;

  logic force_busy = 1'b0;
  logic stub_idle  = 1'b0;

  int checks = 0;
  int errors = 0;
  int cyc = 0;
  int start_err = 0;

  // Transmitter model state
  logic       m_busy = 1'b0;
  logic [9:0] m_sh = '1;
  logic [9:0] m_frame = '0;
  logic [9:0] m_last_frame = '0;
  int         m_bit = 0;
  int         m_cyc = 0;
  logic       tx_line;
  logic [7:0] rxq[$];
  int         start_t[$];
  logic [7:0] start_d[$];

  assign tx_busy = stub_idle ? 1'b0 : (m_busy | force_busy);
  assign tx_line = m_busy ? m_sh[0] : 1'b1;

  uart_tx_feeder #(.DEPTH(16), .AW(4), .TIMEOUT(4)) dut (
    .clk_i(clk), .rst_i(rst), .wr_en_i(wr_en), .wr_data_i(wr_data),
    .full_o(full), .empty_o(empty), .count_o(count), .overflow_o(ovf),
    .clr_ovf_i(clr_ovf), .tx_start_o(tx_start), .tx_data_o(tx_data), .tx_busy_i(tx_busy)
  );

  uart_tx_feeder #(.DEPTH(4), .AW(2), .TIMEOUT(4)) dut4 (
    .clk_i(clk), .rst_i(rst), .wr_en_i(wr_en), .wr_data_i(wr_data),
    .full_o(full4), .empty_o(empty4), .count_o(count4), .overflow_o(ovf4),
    .clr_ovf_i(clr_ovf), .tx_start_o(tx_start4), .tx_data_o(tx_data4), .tx_busy_i(busy4)
  );

  always #5 clk = ~clk;

  always @(posedge clk) cyc <= cyc + 1;

  // Start-pulse monitor
  always @(posedge clk) begin
    if (tx_start) begin
      start_t.push_back(cyc);
      start_d.push_back(tx_data);
      if (tx_busy) start_err <= start_err + 1;
    end
  end

  // Serial transmitter model: 10 bits of BitCyc cycles each; the received byte is rebuilt
  // from the line samples.
  always @(posedge clk) begin
    if (!m_busy) begin
      if (tx_start && !stub_idle) begin
        m_busy <= 1'b1;
        m_sh   <= {1'b1, tx_data, 1'b0};
        m_bit  <= 0;
        m_cyc  <= 0;
      end
    end else begin
      if (m_cyc == 0) m_frame[m_bit] <= tx_line;
      if (m_cyc == BitCyc - 1) begin
        m_cyc <= 0;
        m_sh  <= {1'b1, m_sh[9:1]};
        if (m_bit == 9) begin
          m_busy       <= 1'b0;
          m_last_frame <= m_frame;
          rxq.push_back(m_frame[8:1]);
        end else begin
          m_bit <= m_bit + 1;
        end
      end else begin
        m_cyc <= m_cyc + 1;
      end
    end
  end

  typedef struct {
    logic       rst;
    logic       wr;
    logic [7:0] d;
    logic       exp_start;
    logic [7:0] exp_data;
    logic [4:0] exp_count;
    logic       exp_empty;
    logic       exp_full;
    logic       exp_ovf;
  } vec_t;

  vec_t vecs[6];

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got 0x%0h expected 0x%0h", name, act, exp);
    end
  endtask

  task automatic wait_rx(input int n, input int budget, input string name);
    int k = 0;
    while (rxq.size() < n && k < budget) begin
      step();
      k++;
    end
    check(name, rxq.size(), n);
  endtask

  task automatic wait_idle(input int budget);
    int k = 0;
    while (m_busy && k < budget) begin
      step();
      k++;
    end
    check("model_idle", 32'(m_busy), 0);
  endtask

  task automatic do_reset();
    rst = 1'b1;
    wr_en = 1'b0;
    clr_ovf = 1'b0;
    step();
    rst = 1'b0;
  endtask

  initial begin
    vecs[0] = '{1'b1, 1'b0, 8'h00, 1'b0, 8'h00, 5'd0, 1'b1, 1'b0, 1'b0};
    vecs[1] = '{1'b1, 1'b1, 8'h5A, 1'b0, 8'h00, 5'd0, 1'b1, 1'b0, 1'b0};
    vecs[2] = '{1'b0, 1'b1, 8'hA5, 1'b0, 8'h00, 5'd1, 1'b0, 1'b0, 1'b0};
    vecs[3] = '{1'b0, 1'b0, 8'h00, 1'b1, 8'hA5, 5'd0, 1'b1, 1'b0, 1'b0};
    vecs[4] = '{1'b0, 1'b0, 8'h00, 1'b0, 8'hA5, 5'd0, 1'b1, 1'b0, 1'b0};
    vecs[5] = '{1'b0, 1'b0, 8'h00, 1'b0, 8'hA5, 5'd0, 1'b1, 1'b0, 1'b0};

    // Single byte: reset, one write, launch two edges later, serial frame on the line.
    for (int i = 0; i < 6; i++) begin
      rst = vecs[i].rst;
      wr_en = vecs[i].wr;
      wr_data = vecs[i].d;
      step();
      check($sformatf("v%0d_start", i), 32'(tx_start), 32'(vecs[i].exp_start));
      check($sformatf("v%0d_data", i), 32'(tx_data), 32'(vecs[i].exp_data));
      check($sformatf("v%0d_count", i), 32'(count), 32'(vecs[i].exp_count));
      check($sformatf("v%0d_empty", i), 32'(empty), 32'(vecs[i].exp_empty));
      check($sformatf("v%0d_full", i), 32'(full), 32'(vecs[i].exp_full));
      check($sformatf("v%0d_ovf", i), 32'(ovf), 32'(vecs[i].exp_ovf));
    end
    wr_en = 1'b0;
    wait_rx(1, 200, "single_rx_count");
    if (rxq.size() > 0) check("single_rx_byte", 32'(rxq[0]), 32'h0000_00A5);
    check("single_frame", 32'(m_last_frame), 32'(ExpFrame));
    check("single_one_pulse", start_t.size(), 1);

    // Burst: 16 bytes while the transmitter is held busy, then drain in order.
    wait_idle(200);
    do_reset();
    rxq.delete();
    force_busy = 1'b1;
    for (int i = 0; i < 16; i++) begin
      wr_en = 1'b1;
      wr_data = 8'(i + 1);
      step();
    end
    wr_en = 1'b0;
    check("burst_full", 32'(full), 1);
    check("burst_count", 32'(count), 16);
    check("burst_ovf", 32'(ovf), 0);
    force_busy = 1'b0;
    step();
    check("burst_first_pop_full", 32'(full), 0);
    check("burst_first_pop_count", 32'(count), 15);
    begin
      int k = 0;
      int full_seen = 0;
      while (rxq.size() < 16 && k < 2000) begin
        step();
        if (full) full_seen++;
        k++;
      end
      check("burst_rx_count", rxq.size(), 16);
      check("burst_full_stays_low", full_seen, 0);
    end
    for (int i = 0; i < 16 && i < rxq.size(); i++) begin
      check($sformatf("burst_order%0d", i), 32'(rxq[i]), 32'(i + 1));
    end
    check("burst_start_while_busy", start_err, 0);

    // Overflow: 17 writes into a blocked FIFO, clear versus set priority.
    wait_idle(200);
    do_reset();
    rxq.delete();
    force_busy = 1'b1;
    for (int i = 0; i < 17; i++) begin
      wr_en = 1'b1;
      wr_data = 8'(8'h20 + i);
      step();
      if (i == 15) check("ovf_before_drop", 32'(ovf), 0);
    end
    check("ovf_set", 32'(ovf), 1);
    check("ovf_count", 32'(count), 16);
    wr_data = 8'h31;
    clr_ovf = 1'b1;
    step();
    check("ovf_set_wins", 32'(ovf), 1);
    check("ovf_count_hold", 32'(count), 16);
    wr_en = 1'b0;
    step();
    check("ovf_cleared", 32'(ovf), 0);
    clr_ovf = 1'b0;
    force_busy = 1'b0;
    wait_rx(16, 2000, "ovf_rx_count");
    repeat (60) step();
    check("ovf_no_extra_rx", rxq.size(), 16);
    for (int i = 0; i < 16 && i < rxq.size(); i++) begin
      check($sformatf("ovf_order%0d", i), 32'(rxq[i]), 32'(8'h20 + i));
    end

    // Timeout retry: transmitter never asserts busy.
    wait_idle(200);
    stub_idle = 1'b1;
    do_reset();
    start_t.delete();
    start_d.delete();
    wr_en = 1'b1;
    wr_data = 8'h3C;
    step();
    wr_en = 1'b0;
    repeat (22) step();
    check("tmo_pulses", 32'(start_t.size() >= 4), 1);
    if (start_d.size() > 0) check("tmo_data0", 32'(start_d[0]), 32'h3C);
    for (int i = 1; i < 4 && i < start_t.size(); i++) begin
      check($sformatf("tmo_period%0d", i), start_t[i] - start_t[i-1], 5);
      check($sformatf("tmo_data%0d", i), 32'(start_d[i]), 32'h3C);
    end
    check("tmo_count", 32'(count), 0);
    check("tmo_empty", 32'(empty), 1);
    do_reset();
    stub_idle = 1'b0;

    // Wrap and simultaneous write/pop on the DEPTH=4 instance.
    busy4 = 1'b1;
    do_reset();
    wr_en = 1'b1;
    wr_data = 8'h40;
    step();
    wr_data = 8'h41;
    step();
    wr_en = 1'b0;
    check("wrap_prefill", 32'(count4), 2);
    for (int i = 0; i < 10; i++) begin
      busy4 = 1'b0;
      wr_en = 1'b1;
      wr_data = 8'(8'h42 + i);
      step();
      check($sformatf("wrap_start%0d", i), 32'(tx_start4), 1);
      check($sformatf("wrap_count%0d", i), 32'(count4), 2);
      check($sformatf("wrap_data%0d", i), 32'(tx_data4), 32'(8'h40 + i));
      busy4 = 1'b1;
      wr_en = 1'b0;
      step();
      step();
      busy4 = 1'b0;
      step();
    end
    busy4 = 1'b1;

    // Reset while in WAIT_LO with 3 bytes queued and the transmitter busy.
    wait_idle(200);
    do_reset();
    for (int i = 0; i < 4; i++) begin
      wr_en = 1'b1;
      wr_data = 8'(8'h50 + i);
      step();
    end
    wr_en = 1'b0;
    force_busy = 1'b1;
    step();
    check("rstmid_queued", 32'(count), 3);
    do_reset();
    check("rstmid_count", 32'(count), 0);
    check("rstmid_start", 32'(tx_start), 0);
    check("rstmid_data", 32'(tx_data), 0);
    start_t.delete();
    start_d.delete();
    wr_en = 1'b1;
    wr_data = 8'h77;
    step();
    wr_en = 1'b0;
    repeat (10) step();
    check("rstmid_hold_off", start_t.size(), 0);
    force_busy = 1'b0;
    begin
      int k = 0;
      while (start_t.size() < 1 && k < 200) begin
        step();
        k++;
      end
    end
    repeat (60) step();
    check("rstmid_one_pulse", start_t.size(), 1);
    if (start_d.size() > 0) check("rstmid_pulse_data", 32'(start_d[0]), 32'h77);
    check("rstmid_start_while_busy", start_err, 0);

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule

// File: doc/uart_tx_feeder.md
Name: uart_tx_feeder

Overview:
Byte buffer and launch sequencer that sits directly upstream of the 9600-baud UART transmitter. It accepts bytes from the beamformer result/telemetry logic at any rate into a FIFO. It pops them one at a time onto the transmitter's DATA/START inputs and watches BUSY so that no byte is lost or double-sent. It isolates producers from the ~52k-cycle-per-byte serial rate.

Parameters:
DEPTH, 16, FIFO depth in bytes; must be a power of 2, minimum 2.
AW, 4, pointer width; must equal log2(DEPTH).
TIMEOUT, 4, cycles to wait in WAIT_HI for TX_BUSY to rise before re-pulsing TX_START; range 2..15.

Ports:
CLK  in  1  system clock (50 MHz); all logic on rising edge.
RST  in  1  synchronous reset, active-high.
WR_EN  in  1  write strobe; one byte per asserted cycle.
WR_DATA  in  8  byte to enqueue.
FULL  out  1  COUNT == DEPTH.
EMPTY  out  1  COUNT == 0.
COUNT  out  AW+1  bytes currently held in the FIFO; excludes the byte in flight.
OVERFLOW  out  1  sticky; set when a write is dropped.
CLR_OVF  in  1  clears OVERFLOW.
TX_START  out  1  to transmitter START; one-cycle pulse per launch.
TX_DATA  out  8  to transmitter DATA; held stable from launch until the transmitter goes idle.
TX_BUSY  in  1  from transmitter BUSY.

Behaviour:
- Reset (CLK edge with RST=1): state=IDLE, rd/wr pointers=0, COUNT=0, EMPTY=1, FULL=0, OVERFLOW=0, TX_START=0, TX_DATA=8'h00. RST overrides all other inputs.
- FIFO write: on an edge with WR_EN=1 and FULL=0, WR_DATA is stored at wr_ptr, wr_ptr+1 (wraps mod DEPTH), and COUNT+1.
- Dropped write: WR_EN=1 with FULL=1 drops the byte even if a pop occurs on the same edge. The drop sets OVERFLOW.
- OVERFLOW: CLR_OVF=1 clears it. If set and clear occur on the same edge, set wins.
- Pop: occurs only on the IDLE->LAUNCH transition. It loads TX_DATA<=mem[rd_ptr], rd_ptr+1 (wraps), and COUNT-1.
- Simultaneous write and pop: COUNT is unchanged and both pointers advance.
- FULL, EMPTY and COUNT are decoded from registered state only; there is no combinational path from WR_EN.
- FSM states, all registered:
  IDLE: if EMPTY=0 and TX_BUSY=0, pop and go to LAUNCH; otherwise stay.
  LAUNCH: TX_START=1 for this cycle only; go to WAIT_HI and clear the timeout counter.
  WAIT_HI: TX_START=0. If TX_BUSY=1, go to WAIT_LO. Else increment the timeout counter; when it reaches TIMEOUT-1, go to LAUNCH (re-pulse with the same TX_DATA, no new pop).
  WAIT_LO: if TX_BUSY=0, go to IDLE.
- TX_START is 1 iff state==LAUNCH. TX_DATA changes only on a pop.
- Latency: write on edge n into an empty FIFO, with the transmitter idle:
  - pop on edge n+1;
  - TX_START high during the cycle between edges n+1 and n+2;
  - transmitter BUSY rises after edge n+2;
  - state is WAIT_LO after edge n+3.
- Back-to-back bytes: the next pop occurs on the first edge in IDLE where TX_BUSY=0. That gives at least one idle cycle between BUSY falling and the next TX_START.
- Reset mid-transfer: the FIFO contents and the in-flight byte are discarded. If the transmitter is still BUSY, IDLE holds off until TX_BUSY=0, so no START is issued into a busy transmitter.
- Arithmetic: pointers are AW bits with natural wrap. COUNT is AW+1 bits and never exceeds DEPTH or goes below 0.

Test Plan:
- Single byte: RST 2 cycles, then WR_EN=1 with WR_DATA=8'hA5 for 1 cycle.
  - TX_START pulses for exactly 1 cycle, 2 edges after the write, with TX_DATA=8'hA5.
  - Driving a real transmitter model, the serial line carries start bit 0, then 1,0,1,0,0,1,0,1 (LSB first), then stop bit 1.
- Burst/order: write 8'h01..8'h10 (16 bytes) on consecutive cycles with DEPTH=16.
  - FULL=1 after the 16th write edge, and OVERFLOW stays 0.
  - Each byte is popped as soon as the transmitter goes idle, so FULL drops after the first pop and stays 0 for the rest of the burst.
  - The transmitter receives the 16 bytes in order, each START occurring only while TX_BUSY=0.
- Overflow: with the transmitter held BUSY, write 17 bytes (0x20..0x30).
  - The 17th byte (0x30) is dropped, OVERFLOW=1 and COUNT=16.
  - Assert CLR_OVF together with a further dropped write: OVERFLOW stays 1.
  - Assert CLR_OVF alone: OVERFLOW=0.
- Timeout retry: stub TX_BUSY=0 permanently and write 8'h3C.
  - TX_START pulses every TIMEOUT+1=5 cycles with TX_DATA=8'h3C each time.
  - COUNT stays 0, so there is no extra pop.
- Wrap/simultaneous: with DEPTH=4, perform 10 write/pop cycles where a write coincides with a pop edge.
  - COUNT is unchanged on those edges.
  - Data order is preserved across pointer wrap.
- Reset mid-operation: assert RST while in WAIT_LO with TX_BUSY=1 and 3 bytes queued.
  - After reset, COUNT=0 and TX_START=0.
  - Then write 8'h77 while TX_BUSY is still 1: no TX_START until TX_BUSY falls, then exactly 1 pulse with 8'h77.
